// File: rtl/mse_serial_slave.sv
// mse_serial_slave: slave endpoint of the MSE serial link.
// A frame opens on a falling SLE. The slave samples SDI at mid-bit and drives SDO
// MSB first. The received word goes out on a rx_valid/rx_ready handshake, and the
// word to return comes in through tx_data/tx_load.
// Optional build macro MSE_SLAVE_PARITY_EN adds an even-parity bit to each frame.
module mse_serial_slave #(
  parameter int WIDTH       = 8,
  parameter int CLK_PER_BIT = 4
) (
  input  logic             csi_MCLK_clk,
  input  logic             rsi_MRST_reset_n,
  input  logic             sdi_i,
  input  logic             sle_i,
  output logic             sdo_o,
  output logic             sdo_dir,
  output logic             srdy_o,
  output logic             srdy_dir,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_busy,
  output logic             frame_err,
  output logic             overrun
);

`ifdef MSE_SLAVE_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int DIV_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_PER_BIT / 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_next;

  logic sdi_meta, sdi_s;
  logic sle_meta, sle_s, sle_q;

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-2:0] rx_shift;
  logic [WIDTH-1:0]      tx_buf;

  logic                  sle_fall;
  logic                  sample_pt;
  logic                  bit_end;
  logic                  last_sample;
  logic                  abort;
  logic                  commit;
  logic                  par_err;
  logic                  parity_ok;
  logic [FRAME_BITS-1:0] rx_full;
  logic [WIDTH-1:0]      rx_word;
  logic [FRAME_BITS-1:0] tx_frame;

  // Two-flop synchronisers for the pin inputs, plus a delayed SLE copy for edge detection.
  // They reset to 0, so an SLE that is already low when reset is released is never seen as a falling edge.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      sdi_meta <= 1'b0;
      sdi_s    <= 1'b0;
      sle_meta <= 1'b0;
      sle_s    <= 1'b0;
      sle_q    <= 1'b0;
    end else begin
      sdi_meta <= sdi_i;
      sdi_s    <= sdi_meta;
      sle_meta <= sle_i;
      sle_s    <= sle_meta;
      sle_q    <= sle_s;
    end
  end

  assign sle_fall    = sle_q & ~sle_s;
  assign sample_pt   = (state == SHIFT) && (div_cnt == DIV_HALF);
  assign bit_end     = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign last_sample = sample_pt && (bit_cnt == BIT_LAST);
  assign abort       = (state == SHIFT) && sle_s;

  // Assemble the frame as it stands after this clock's sample, and check its parity when enabled.
  always_comb begin
    rx_full = {rx_shift, sdi_s};
`ifdef MSE_SLAVE_PARITY_EN
    rx_word   = rx_full[FRAME_BITS-1:1];
    parity_ok = ~(^rx_full);
    tx_frame  = {tx_buf, ^tx_buf};
`else
    rx_word   = rx_full;
    parity_ok = 1'b1;
    tx_frame  = tx_buf;
`endif
    commit  = last_sample & ~abort & parity_ok;
    par_err = last_sample & ~abort & ~parity_ok;
  end

  // Frame state register.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) state <= IDLE;
    else                   state <= state_next;
  end

  // Next-state logic. A frame ends at the mid-bit sample of its last bit, and an SLE that rises earlier aborts it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sle_fall) state_next = SHIFT;
      SHIFT: begin
        if (abort)            state_next = IDLE;
        else if (last_sample) state_next = DONE;
      end
      DONE:    if (sle_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit timing counters and the tx/rx shift registers.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
    end else if (state == IDLE) begin
      if (sle_fall) begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        tx_shift <= tx_frame;
        rx_shift <= '0;
      end
    end else if (state == SHIFT) begin
      if (bit_end) begin
        div_cnt  <= '0;
        bit_cnt  <= bit_cnt + 1'b1;
        tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (sample_pt) rx_shift <= rx_full[FRAME_BITS-2:0];
    end
  end

  // Local-side state: tx buffer, received word, handshake, error pulse, overrun and SRDY enable.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      tx_buf    <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      srdy_dir  <= 1'b0;
    end else begin
      srdy_dir  <= 1'b1;
      frame_err <= abort | par_err;
      if (tx_load && !tx_busy) tx_buf <= tx_data;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign sdo_o   = (state == SHIFT) & tx_shift[FRAME_BITS-1];
  assign sdo_dir = (state != IDLE);
  assign tx_busy = (state != IDLE);
  assign srdy_o  = srdy_dir & (state == IDLE) & ~rx_valid;

endmodule

// File: tb/tb_mse_serial_slave.sv
// tb_mse_serial_slave: self-checking bench for mse_serial_slave.
// The bench acts as the link master. Each expected received word is queued when
// its frame is driven. A monitor pops the queue and compares it when rx_valid rises.
module tb_mse_serial_slave;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
`ifdef MSE_SLAVE_PARITY_EN
  localparam int FB = WIDTH + 1;
`else
  localparam int FB = WIDTH;
`endif

  logic             clk;
  logic             rst_n;
  logic             sdi_i;
  logic             sle_i;
  logic             sdo_o;
  logic             sdo_dir;
  logic             srdy_o;
  logic             srdy_dir;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_busy;
  logic             frame_err;
  logic             overrun;

  int checks = 0;
  int fails  = 0;
  int err_pulses = 0;
  int e0;
  logic rx_valid_prev = 1'b0;
  logic [WIDTH-1:0] exp_rx[$];

  mse_serial_slave #(.WIDTH(WIDTH), .CLK_PER_BIT(CPB)) dut (
    .csi_MCLK_clk     (clk),
    .rsi_MRST_reset_n (rst_n),
    .sdi_i            (sdi_i),
    .sle_i            (sle_i),
    .sdo_o            (sdo_o),
    .sdo_dir          (sdo_dir),
    .srdy_o           (srdy_o),
    .srdy_dir         (srdy_dir),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .tx_data          (tx_data),
    .tx_load          (tx_load),
    .tx_busy          (tx_busy),
    .frame_err        (frame_err),
    .overrun          (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [FB-1:0] mkFrame(input logic [WIDTH-1:0] w);
`ifdef MSE_SLAVE_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic checkReset(input string tag);
    checkOutput(tag, 32'({sdo_o, sdo_dir, srdy_o, srdy_dir, rx_valid, tx_busy, frame_err, overrun}), 0);
    checkOutput({tag, "_rxdata"}, 32'(rx_data), 0);
  endtask

  // Count frame_err pulses, and check each newly valid rx word against the scoreboard.
  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (rx_valid && !rx_valid_prev) begin
      if (exp_rx.size() == 0) checkOutput("rx_unexpected", 32'(exp_rx.size()), 1);
      else checkOutput("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
    rx_valid_prev = rx_valid;
  end

  task automatic loadTx(input logic [WIDTH-1:0] w);
    @(negedge clk);
    tx_data = w;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic pulseReady();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic endFrame();
    @(negedge clk);
    sle_i = 1'b1;
    sdi_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Drive one frame with SLE low. SDO is sampled at the slave's mid-bit point, which sits
  // 2 synchroniser clocks plus 1 edge-detect clock after the pin bit boundary.
  // load_at and reset_at give the clock index at which to attempt a tx_load or pulse reset.
  task automatic applyStimulus(input logic [FB-1:0] frame, input int nbits, input bit expect_commit,
                               input bit check_sdo, input logic [FB-1:0] exp_sdo,
                               input int load_at, input int reset_at);
    logic [FB-1:0] cap;
    int b;
    int s;
    cap = '0;
    if (expect_commit) exp_rx.push_back(frame[FB-1 -: WIDTH]);
    @(negedge clk);
    sle_i = 1'b0;
    for (int j = 0; j <= nbits * CPB + CPB; j++) begin
      if (j > 0) @(negedge clk);
      b = j / CPB;
      if (b < nbits) sdi_i = frame[FB-1-b];
      else           sdi_i = 1'b0;
      if (j == load_at) begin
        tx_data = 8'hFF;
        tx_load = 1'b1;
      end else begin
        tx_load = 1'b0;
      end
      if (j == reset_at) begin
        rst_n = 1'b0;
        #1;
        checkReset("reset_mid");
      end
      if (j == reset_at + 1) rst_n = 1'b1;
      if (j >= 3 + CPB / 2 && ((j - 3 - CPB / 2) % CPB) == 0) begin
        s = (j - 3 - CPB / 2) / CPB;
        if (s < nbits) cap[FB-1-s] = sdo_o;
      end
    end
    if (check_sdo) checkOutput("sdo_bits", 32'(cap), 32'(exp_sdo));
  endtask

  initial begin
    rst_n    = 1'b0;
    sle_i    = 1'b1;
    sdi_i    = 1'b0;
    rx_ready = 1'b0;
    tx_data  = '0;
    tx_load  = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("srdy_dir", 32'(srdy_dir), 1);
    checkOutput("srdy_idle", 32'(srdy_o), 1);

    // First frame: return A5, receive 3C.
    loadTx(8'hA5);
    applyStimulus(mkFrame(8'h3C), FB, 1'b1, 1'b1, mkFrame(8'hA5), -1, -1);
    checkOutput("f1_valid", 32'(rx_valid), 1);
    checkOutput("f1_srdy", 32'(srdy_o), 0);
    checkOutput("f1_dir_held", 32'(sdo_dir), 1);
    endFrame();
    checkOutput("f1_dir_off", 32'(sdo_dir), 0);
    checkOutput("f1_busy_off", 32'(tx_busy), 0);

    // Overrun: the word stays unread while a second frame completes.
    applyStimulus(mkFrame(8'h55), FB, 1'b0, 1'b1, mkFrame(8'hA5), -1, -1);
    endFrame();
    checkOutput("ovr_flag", 32'(overrun), 1);
    checkOutput("ovr_keep", 32'(rx_data), 32'h3C);
    pulseReady();
    checkOutput("rd_valid", 32'(rx_valid), 0);
    checkOutput("rd_srdy", 32'(srdy_o), 1);

    // Abort after 5 bits.
    e0 = err_pulses;
    applyStimulus(mkFrame(8'hC3), 5, 1'b0, 1'b0, '0, -1, -1);
    endFrame();
    checkOutput("abort_err", 32'(err_pulses - e0), 1);
    checkOutput("abort_valid", 32'(rx_valid), 0);
    checkOutput("abort_dir", 32'(sdo_dir), 0);
    checkOutput("abort_busy", 32'(tx_busy), 0);
    checkOutput("abort_overrun", 32'(overrun), 1);

    // A tx_load during SHIFT is ignored, and the buffer is sent again.
    loadTx(8'h0F);
    applyStimulus(mkFrame(8'h96), FB, 1'b1, 1'b1, mkFrame(8'h0F), 10, -1);
    endFrame();
    pulseReady();
    applyStimulus(mkFrame(8'h5A), FB, 1'b1, 1'b1, mkFrame(8'h0F), -1, -1);
    endFrame();

    // Reset in bit 3, then a clean frame.
    applyStimulus(mkFrame(8'hE7), FB, 1'b0, 1'b0, '0, -1, 3 * CPB + 2);
    endFrame();
    checkOutput("post_reset_valid", 32'(rx_valid), 0);
    checkOutput("post_reset_overrun", 32'(overrun), 0);
    checkOutput("post_reset_srdy_dir", 32'(srdy_dir), 1);
    loadTx(8'h42);
    applyStimulus(mkFrame(8'h81), FB, 1'b1, 1'b1, mkFrame(8'h42), -1, -1);
    endFrame();
    checkOutput("f81_data", 32'(rx_data), 32'h81);
    pulseReady();

`ifdef MSE_SLAVE_PARITY_EN
    // Bad parity is rejected; good parity is accepted.
    e0 = err_pulses;
    applyStimulus({8'h03, 1'b1}, FB, 1'b0, 1'b1, mkFrame(8'h42), -1, -1);
    endFrame();
    checkOutput("par_err", 32'(err_pulses - e0), 1);
    checkOutput("par_valid", 32'(rx_valid), 0);
    checkOutput("par_overrun", 32'(overrun), 0);
    applyStimulus({8'h03, 1'b0}, FB, 1'b1, 1'b1, mkFrame(8'h42), -1, -1);
    endFrame();
    checkOutput("par_ok_data", 32'(rx_data), 32'h03);
    pulseReady();
`endif

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", 32'(exp_rx.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
